ysyx_22040088_mdu_seq: RTL and testbench

//  Multi-cycle sequencer and datapath for the RV64M word ops MULW/DIVW/REMW (plus DIVUW/REMUW).

---
 rtl/ysyx_22040088_mdu_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_ysyx_22040088_mdu_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040088_mdu_seq.sv
// ysyx_22040088_mdu_seq
//   Multi-cycle multiply/divide unit for the RV64M word ops MULW, DIVW,
//   REMW, DIVUW and REMUW. It sits beside the single-cycle ALU, so the
//   ALU itself needs no multiplier or divider. The core stalls on
//   in_ready and out_valid while an op is in progress.
//
//   MULW uses shift-add. DIV/REM use restoring division on the operand
//   magnitudes, and the sign is fixed up at the end. Each op takes one
//   radix-2 step per cycle over WLEN cycles. Divide-by-zero and signed
//   overflow are resolved when the request is accepted.
//
// Configuration macro:
//   YSYX_22040088_MDU_FAST_MUL_EN - when defined, MULW is computed with a
//   single-cycle WLEN x WLEN product at accept and goes straight to DONE.
//   When undefined, MULW is iterative and no '*' operator is synthesised.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous reset, active-high
//   in_valid     request valid
//   in_ready     unit can accept a request (IDLE)
//   in_op        one-hot {remw, divw, mulw}
//   in_unsigned  1 = DIVUW/REMUW semantics; ignored for mulw
//   in_src1      rs1; only [WLEN-1:0] used
//   in_src2      rs2; only [WLEN-1:0] used
//   flush        abort any op in flight; highest priority
//   out_valid    result valid (DONE)
//   out_ready    consumer takes the result
//   out_result   32-bit result sign-extended to XLEN
//   busy         unit is not IDLE
module ysyx_22040088_mdu_seq #(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    localparam int CW = $clog2(WLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    function automatic logic [XLEN-1:0] sext(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;        // one-hot {rem, div, mul}
    logic              r_neg_q;     // quotient must be negated
    logic              r_neg_r;     // remainder must be negated
    // Shared datapath registers:
    //   mul: r_acc = partial product, r_x = multiplicand (shifts left),
    //        r_y = multiplier (shifts right)
    //   div: r_acc[WLEN:0] = partial remainder, r_x[WLEN-1:0] = dividend
    //        shifting out / quotient shifting in, r_y = divisor magnitude
    logic [2*WLEN-1:0] r_acc;
    logic [2*WLEN-1:0] r_x;
    logic [WLEN-1:0]   r_y;
    logic [XLEN-1:0]   r_result;

    // ---------------- accept-time decode ----------------
    logic [WLEN-1:0]   w_a;
    logic [WLEN-1:0]   w_b;
    logic              w_op_ok;
    logic              w_accept;
    logic              w_signed_div;
    logic              w_s1;
    logic              w_s2;
    logic [WLEN-1:0]   w_mag_a;
    logic [WLEN-1:0]   w_mag_b;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_unused;

    assign w_a          = in_src1[WLEN-1:0];
    assign w_b          = in_src2[WLEN-1:0];
    assign w_op_ok      = (in_op == 3'b001) || (in_op == 3'b010) || (in_op == 3'b100);
    assign w_accept     = (r_state == S_IDLE) && in_valid && w_op_ok && !flush;
    assign w_signed_div = !in_unsigned && !in_op[0];
    assign w_s1         = w_signed_div && w_a[WLEN-1];
    assign w_s2         = w_signed_div && w_b[WLEN-1];
    assign w_mag_a      = w_s1 ? -w_a : w_a;
    assign w_mag_b      = w_s2 ? -w_b : w_b;
    assign w_div_zero   = !in_op[0] && (w_b == '0);
    assign w_ovf        = w_signed_div && (w_a == {1'b1, {(WLEN-1){1'b0}}}) && (w_b == '1);
    // The upper halves of the sources are architecturally ignored.
    assign w_unused     = ^{in_src1[XLEN-1:WLEN], in_src2[XLEN-1:WLEN]};

`ifdef YSYX_22040088_MDU_FAST_MUL_EN
    logic [WLEN-1:0]   w_fast_prod;
    // Only the low word of the product is ever observed.
    assign w_fast_prod = w_a * w_b;
`endif

    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        if (w_div_zero) begin
            w_special     = 1'b1;
            w_special_res = in_op[1] ? '1 : sext(w_a);
        end else if (w_ovf) begin
            // Quotient wraps to the dividend; remainder is zero.
            w_special     = 1'b1;
            w_special_res = in_op[1] ? sext(w_a) : '0;
        end
`ifdef YSYX_22040088_MDU_FAST_MUL_EN
        else if (in_op[0]) begin
            w_special     = 1'b1;
            w_special_res = sext(w_fast_prod);
        end
`endif
    end

    // ---------------- one iteration step ----------------
    logic [2*WLEN-1:0] w_mul_acc;
    logic [WLEN:0]     w_rem_sh;
    logic [WLEN:0]     w_diff;
    logic              w_qbit;
    logic [WLEN:0]     w_rem_nxt;
    logic [WLEN-1:0]   w_quo_nxt;
    logic [WLEN-1:0]   w_q_fin;
    logic [WLEN-1:0]   w_r_fin;
    logic [WLEN-1:0]   w_word;

    assign w_mul_acc = r_y[0] ? (r_acc + r_x) : r_acc;
    // Restoring division: bring down the next dividend bit, try to subtract.
    assign w_rem_sh  = {r_acc[WLEN-1:0], r_x[WLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_y};
    assign w_qbit    = !w_diff[WLEN];
    assign w_rem_nxt = w_qbit ? w_diff : w_rem_sh;
    assign w_quo_nxt = {r_x[WLEN-2:0], w_qbit};
    assign w_q_fin   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fin   = r_neg_r ? -w_rem_nxt[WLEN-1:0] : w_rem_nxt[WLEN-1:0];
    assign w_word    = r_op[0] ? w_mul_acc[WLEN-1:0] :
                       r_op[1] ? w_q_fin : w_r_fin;

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= in_op;
            r_neg_q <= w_s1 ^ w_s2;
            r_neg_r <= w_s1;    // remainder takes the dividend's sign
            if (w_special) begin
                r_result <= w_special_res;
            end else begin
                r_cnt <= CW'(WLEN);
                r_acc <= '0;
                // For MULW the magnitudes equal the raw operands.
                r_x   <= {{WLEN{1'b0}}, w_mag_a};
                r_y   <= w_mag_b;
            end
        end else if (r_state == S_CALC && !flush) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_op[0]) begin
                r_acc <= w_mul_acc;
                r_x   <= r_x << 1;
                r_y   <= r_y >> 1;
            end else begin
                r_acc <= {{(WLEN-1){1'b0}}, w_rem_nxt};
                r_x   <= {{WLEN{1'b0}}, w_quo_nxt};
            end
            if (r_cnt == CW'(1)) r_result <= sext(w_word);
        end
    end

    assign out_result = r_result;

endmodule

// File: tb/tb_ysyx_22040088_mdu_seq.sv
// Directed testbench for ysyx_22040088_mdu_seq: arithmetic vectors,
// special cases, backpressure, flush and mid-op reset.
module tb_ysyx_22040088_mdu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic        in_unsigned;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b010;
    localparam logic [2:0] OP_REM = 3'b100;
    localparam int         DIV_LAT = 33;
`ifdef YSYX_22040088_MDU_FAST_MUL_EN
    localparam int         MUL_LAT = 1;
`else
    localparam int         MUL_LAT = 33;
`endif

    always #5 clk = ~clk;

    ysyx_22040088_mdu_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_unsigned (in_unsigned),
        .in_src1     (in_src1),
        .in_src2     (in_src2),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge; it is accepted on the following edge.
    task automatic start(input logic [2:0] op, input logic uns,
                         input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        in_valid    = 1'b1;
        in_op       = op;
        in_unsigned = uns;
        in_src1     = a;
        in_src2     = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count negedges after the accept edge until out_valid is seen.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        check({tag, "_seen"}, 64'(out_valid), 64'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic uns,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat);
        int lat;
        start(op, uns, a, b);
        wait_valid(tag, lat);
        check({tag, "_res"}, out_result, exp);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        release_result();
    endtask

    task automatic check_idle(input string tag, input logic [63:0] exp_result, input logic chk_result);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        if (chk_result) check({tag, "_out_result"}, out_result, exp_result);
    endtask

    initial begin
        int lat;
        int nv;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_op       = 3'b000;
        in_unsigned = 1'b0;
        in_src1     = '0;
        in_src2     = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset", 64'h0, 1'b1);

        // Arithmetic: 7 * -3 = -21; -7 / 2 = -3 rem -1 (truncating);
        // 4294967289 = 2 * 2147483644 + 1 unsigned.
        run("mulw",  OP_MUL, 1'b0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
        run("divw",  OP_DIV, 1'b0, 64'hDEAD_BEEF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
        run("remw",  OP_REM, 1'b0, 64'h0000_0000_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, DIV_LAT);
        run("divuw", OP_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h2, 64'h0000_0000_7FFF_FFFC, DIV_LAT);
        run("remuw", OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h2, 64'h0000_0000_0000_0001, DIV_LAT);
        run("divw_mixed", OP_DIV, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, DIV_LAT);

        // Special cases resolve in one cycle.
        run("divw_z",  OP_DIV, 1'b0, 64'h55, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("remw_z",  OP_REM, 1'b0, 64'h1234_5678, 64'h0, 64'h0000_0000_1234_5678, 1);
        run("divuw_z", OP_DIV, 1'b1, 64'h9, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("remuw_z", OP_REM, 1'b1, 64'h8000_0001, 64'h0, 64'hFFFF_FFFF_8000_0001, 1);
        run("divw_ovf", OP_DIV, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run("remw_ovf", OP_REM, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 1);
        // Same operands unsigned are a normal division: 0x80000000 / 0xFFFFFFFF = 0.
        run("divuw_big", OP_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, DIV_LAT);

        // A request whose op is not one-hot is ignored.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'b011;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_idle("bad_op", 64'h0, 1'b0);

        // Backpressure: 100 / 7 = 14 held for 10 cycles while a new request waits.
        start(OP_DIV, 1'b0, 64'd100, 64'd7);
        wait_valid("bp", lat);
        in_valid = 1'b1;
        in_op    = OP_MUL;
        in_src1  = 64'd5;
        in_src2  = 64'd6;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid",    64'(out_valid), 64'd1);
            check("bp_result",   out_result,     64'd14);
            check("bp_in_ready", 64'(in_ready),  64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 begin
            out_ready = 1'b0;
            in_valid  = 1'b0;
        end
        @(negedge clk);
        check_idle("bp_release", 64'h0, 1'b0);

        // flush and in_valid together in IDLE: not accepted.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_DIV;
        in_src1  = 64'd9;
        in_src2  = 64'd3;
        flush    = 1'b1;
        @(posedge clk);
        #1 begin
            in_valid = 1'b0;
            flush    = 1'b0;
        end
        @(negedge clk);
        check_idle("flush_idle", 64'h0, 1'b0);

        // flush in CALC cycle 5.
        start(OP_DIV, 1'b0, 64'h1234, 64'h10);
        repeat (5) @(negedge clk);
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_idle("flush_calc", 64'h0, 1'b0);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("flush_no_valid", 64'(nv), 64'd0);
        run("mul_after_flush", OP_MUL, 1'b0, 64'd3, 64'd4, 64'hC, MUL_LAT);

        // Reset in the middle of a division clears everything, including the result.
        start(OP_DIV, 1'b0, 64'd1000, 64'd3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("rst_calc", 64'h0, 1'b1);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("rst_no_valid", 64'(nv), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
